canvas_centering_reader: RTL and testbench

Read-side counterpart of the drawing canvas: on `start`, snapshots the flat canvas bit vector, finds the bounding box of the set pixels, and streams the canvas back out one pixel per handshake, translated so the drawn digit is centred. Sits between the canvas layer and the digit classifier input, so the classifier sees position-normalised 32×32 images.

---
 rtl/canvas_pkg.sv | 20 ++
 rtl/canvas_centering_reader_first_last_one.sv | 26 ++
 rtl/canvas_centering_reader.sv | 219 +++++++++++++++++++++
 tb/tb_canvas_centering_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, reader FSM encoding and the flat-bitmap index helper.
package canvas_pkg;

  localparam int unsigned CANVAS_W = 32;
  localparam int unsigned CANVAS_H = 32;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StCalc,
    StStream,
    StDone
  } state_e;

  function automatic int unsigned pix_index(input int unsigned x, input int unsigned y,
                                            input int unsigned w);
    return x + w * y;
  endfunction

endpackage

// File: rtl/canvas_centering_reader_first_last_one.sv
// Combinational scan of a vector: any bit set, plus lowest and highest set index.
module first_last_one #(
  parameter int unsigned Width = 32,
  parameter int unsigned IW    = $clog2(Width)
) (
  input  logic [Width-1:0] vec,
  output logic             any,
  output logic [IW-1:0]    lo,
  output logic [IW-1:0]    hi
);

  assign any = |vec;

  always_comb begin
    lo = '0;
    hi = '0;
    // Descending pass leaves the lowest set index; ascending pass the highest.
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec[i]) lo = IW'(i);
    end
    for (int i = 0; i < Width; i++) begin
      if (vec[i]) hi = IW'(i);
    end
  end

endmodule

// File: rtl/canvas_centering_reader.sv
// Snapshots the canvas, finds the ink bounding box and streams the image back out
// translated so the drawn digit sits in the centre.
module canvas_centering_reader
  import canvas_pkg::*;
#(
  parameter int unsigned canvasWidth  = CANVAS_W,
  parameter int unsigned canvasHeight = CANVAS_H,
  parameter int unsigned XW           = $clog2(canvasWidth),
  parameter int unsigned YW           = $clog2(canvasHeight)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [canvasWidth*canvasHeight-1:0] canvas,
  output logic                                busy,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic                                pix_data,
  output logic [XW-1:0]                       pix_x,
  output logic [YW-1:0]                       pix_y,
  output logic                                pix_last,
  output logic                                done,
  output logic                                was_empty,
  output logic [XW-1:0]                       bbox_min_x,
  output logic [XW-1:0]                       bbox_max_x,
  output logic [YW-1:0]                       bbox_min_y,
  output logic [YW-1:0]                       bbox_max_y
);

  localparam int unsigned N  = canvasWidth * canvasHeight;
  localparam int unsigned IW = $clog2(N);
  localparam logic [XW-1:0] XMax = XW'(canvasWidth - 1);
  localparam logic [YW-1:0] YMax = YW'(canvasHeight - 1);

  state_e                 state_q, state_d;
  logic [N-1:0]           snap_q, snap_d;
  logic [YW-1:0]          row_q, row_d;
  logic [canvasWidth-1:0] col_acc_q, col_acc_d;
  logic                   found_y_q, found_y_d;
  logic [YW-1:0]          min_y_q, min_y_d, max_y_q, max_y_d;
  logic [XW-1:0]          bmin_x_q, bmin_x_d, bmax_x_q, bmax_x_d;
  logic [YW-1:0]          bmin_y_q, bmin_y_d, bmax_y_q, bmax_y_d;
  logic                   empty_q, empty_d;
  logic signed [XW:0]     shift_x_q, shift_x_d;
  logic signed [YW:0]     shift_y_q, shift_y_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   valid_q, valid_d;

  logic [canvasWidth-1:0] row_bits;
  logic [IW-1:0]          row_base;
  logic                   col_any;
  logic [XW-1:0]          col_lo, col_hi;
  logic signed [XW+1:0]   sum_x, src_x;
  logic signed [YW+1:0]   sum_y, src_y;
  logic                   src_in;
  logic [IW-1:0]          src_idx;

  first_last_one #(
    .Width (canvasWidth),
    .IW    (XW)
  ) u_col (
    .vec (col_acc_q),
    .any (col_any),
    .lo  (col_lo),
    .hi  (col_hi)
  );

  assign row_base = IW'(pix_index(0, 32'(row_q), canvasWidth));
  assign row_bits = snap_q[row_base +: canvasWidth];

  // Two guard bits keep W-1-min-max exact before the floor halving.
  assign sum_x = $signed({2'b00, XMax}) - $signed({2'b00, col_lo}) - $signed({2'b00, col_hi});
  assign sum_y = $signed({2'b00, YMax}) - $signed({2'b00, min_y_q}) - $signed({2'b00, max_y_q});

  assign src_x   = $signed({2'b00, x_q}) - $signed({shift_x_q[XW], shift_x_q});
  assign src_y   = $signed({2'b00, y_q}) - $signed({shift_y_q[YW], shift_y_q});
  // Power-of-two canvas: in range exactly when both guard bits are clear.
  assign src_in  = (src_x[XW+1:XW] == 2'b00) && (src_y[YW+1:YW] == 2'b00);
  assign src_idx = IW'(pix_index(32'(src_x[XW-1:0]), 32'(src_y[YW-1:0]), canvasWidth));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    row_d     = row_q;
    col_acc_d = col_acc_q;
    found_y_d = found_y_q;
    min_y_d   = min_y_q;
    max_y_d   = max_y_q;
    bmin_x_d  = bmin_x_q;
    bmax_x_d  = bmax_x_q;
    bmin_y_d  = bmin_y_q;
    bmax_y_d  = bmax_y_q;
    empty_d   = empty_q;
    shift_x_d = shift_x_q;
    shift_y_d = shift_y_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d    = canvas;
          row_d     = '0;
          col_acc_d = '0;
          found_y_d = 1'b0;
          min_y_d   = '0;
          max_y_d   = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        col_acc_d = col_acc_q | row_bits;
        if (|row_bits) begin
          if (!found_y_q) begin
            min_y_d   = row_q;
            found_y_d = 1'b1;
          end
          max_y_d = row_q;
        end
        if (row_q == YMax) state_d = StCalc;
        else row_d = row_q + 1'b1;
      end
      StCalc: begin
        if (col_any) begin
          shift_x_d = $signed(sum_x[XW+1:1]);
          shift_y_d = $signed(sum_y[YW+1:1]);
          bmin_x_d  = col_lo;
          bmax_x_d  = col_hi;
          bmin_y_d  = min_y_q;
          bmax_y_d  = max_y_q;
          empty_d   = 1'b0;
        end else begin
          shift_x_d = '0;
          shift_y_d = '0;
          bmin_x_d  = '0;
          bmax_x_d  = '0;
          bmin_y_d  = '0;
          bmax_y_d  = '0;
          empty_d   = 1'b1;
        end
        x_d     = '0;
        y_d     = '0;
        valid_d = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (pix_ready) begin
          // Counters wrap to zero naturally after the final pixel.
          x_d = x_q + 1'b1;
          if (x_q == XMax) begin
            y_d = y_q + 1'b1;
            if (y_q == YMax) begin
              valid_d = 1'b0;
              state_d = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      row_q     <= '0;
      col_acc_q <= '0;
      found_y_q <= 1'b0;
      min_y_q   <= '0;
      max_y_q   <= '0;
      bmin_x_q  <= '0;
      bmax_x_q  <= '0;
      bmin_y_q  <= '0;
      bmax_y_q  <= '0;
      empty_q   <= 1'b0;
      shift_x_q <= '0;
      shift_y_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      row_q     <= row_d;
      col_acc_q <= col_acc_d;
      found_y_q <= found_y_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      bmin_x_q  <= bmin_x_d;
      bmax_x_q  <= bmax_x_d;
      bmin_y_q  <= bmin_y_d;
      bmax_y_q  <= bmax_y_d;
      empty_q   <= empty_d;
      shift_x_q <= shift_x_d;
      shift_y_q <= shift_y_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign pix_valid  = valid_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_data   = valid_q && src_in && snap_q[src_idx];
  assign pix_last   = valid_q && (x_q == XMax) && (y_q == YMax);
  assign was_empty  = empty_q;
  assign bbox_min_x = bmin_x_q;
  assign bbox_max_x = bmax_x_q;
  assign bbox_min_y = bmin_y_q;
  assign bbox_max_y = bmax_y_q;

endmodule

// File: tb/tb_canvas_centering_reader.sv
// Directed bench for canvas_centering_reader: latency, centring, stalls, snapshot
// isolation and mid-stream reset on a 32x32 canvas.
module tb_canvas_centering_reader;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int N  = W * H;
  localparam int XW = 5;
  localparam int YW = 5;

  logic          clk = 1'b0;
  logic          rst, start, pix_ready;
  logic [N-1:0]  canvas;
  logic          busy, pix_valid, pix_data, pix_last, done, was_empty;
  logic [XW-1:0] pix_x, bbox_min_x, bbox_max_x;
  logic [YW-1:0] pix_y, bbox_min_y, bbox_max_y;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  canvas_centering_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .canvas     (canvas),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_last   (pix_last),
    .done       (done),
    .was_empty  (was_empty),
    .bbox_min_x (bbox_min_x),
    .bbox_max_x (bbox_max_x),
    .bbox_min_y (bbox_min_y),
    .bbox_max_y (bbox_max_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] rect(input int x0, input int x1, input int y0, input int y1);
    logic [N-1:0] r;
    r = '0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) r[x + W * y] = 1'b1;
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_bbox(input string tag, input int mnx, input int mxx, input int mny,
                          input int mxy, input bit empty);
    chk({tag, " min_x"}, 32'(bbox_min_x), mnx);
    chk({tag, " max_x"}, 32'(bbox_max_x), mxx);
    chk({tag, " min_y"}, 32'(bbox_min_y), mny);
    chk({tag, " max_y"}, 32'(bbox_max_y), mxy);
    chk({tag, " was_empty"}, 32'(was_empty), 32'(empty));
  endtask

  // Entered and left just after a rising edge.
  task automatic run_stream(input string tag, input logic [N-1:0] exp_img, input int exp_ones,
                            input bit rnd, input bit perturb, input int abort_at);
    int k = 0, ones = 0, cyc = 0;
    int derr = 0, cerr = 0, lerr = 0, serr = 0;
    bit stalled = 1'b0;
    logic [XW+YW+1:0] held = '0;
    while (k < N && cyc < 8000) begin
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (perturb && k == 100) begin
        canvas = '1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (stalled && (!pix_valid || {pix_data, pix_last, pix_x, pix_y} !== held)) serr++;
      stalled = 1'b0;
      if (pix_valid) begin
        if (pix_ready) begin
          if (pix_x !== XW'(k % W) || pix_y !== YW'(k / W)) cerr++;
          if (pix_data !== exp_img[k]) derr++;
          if (pix_last !== (k == N - 1)) lerr++;
          if (pix_data === 1'b1) ones++;
          k++;
        end else begin
          stalled = 1'b1;
          held    = {pix_data, pix_last, pix_x, pix_y};
        end
      end
      if (abort_at >= 0 && k == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b0;
    if (abort_at >= 0) begin
      chk({tag, " reached abort point"}, 32'(k), 32'(abort_at));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk({tag, " busy after rst"}, 32'(busy), 0);
      chk({tag, " valid after rst"}, 32'(pix_valid), 0);
      chk({tag, " done after rst"}, 32'(done), 0);
      chk({tag, " pix_x after rst"}, 32'(pix_x), 0);
      chk({tag, " pix_y after rst"}, 32'(pix_y), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " no done later"}, 32'(done), 0);
      @(posedge clk); #1;
      return;
    end
    chk({tag, " pixel count"}, 32'(k), 32'(N));
    chk({tag, " coord errors"}, 32'(cerr), 0);
    chk({tag, " data errors"}, 32'(derr), 0);
    chk({tag, " last errors"}, 32'(lerr), 0);
    chk({tag, " ones"}, 32'(ones), 32'(exp_ones));
    if (rnd) chk({tag, " stall errors"}, 32'(serr), 0);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 1);
    chk({tag, " busy in done"}, 32'(busy), 1);
    chk({tag, " valid in done"}, 32'(pix_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(done), 0);
    chk({tag, " busy falls"}, 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  logic [N-1:0] img;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    canvas = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset valid", 32'(pix_valid), 0);
    chk("reset data", 32'(pix_data), 0);
    chk("reset last", 32'(pix_last), 0);
    chk("reset done", 32'(done), 0);
    chk("reset pix_x", 32'(pix_x), 0);
    chk("reset pix_y", 32'(pix_y), 0);
    chk_bbox("reset", 0, 0, 0, 0, 1'b0);

    // Empty canvas with latency check: start sampled at edge T, valid after edge T+33.
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    chk("empty busy at T+1", 32'(busy), 1);
    chk("empty valid at T+1", 32'(pix_valid), 0);
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("empty valid in CALC", 32'(pix_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("empty valid at T+34", 32'(pix_valid), 1);
    @(posedge clk); #1;
    run_stream("empty", '0, 0, 1'b0, 1'b0, -1);
    chk_bbox("empty", 0, 0, 0, 0, 1'b1);

    // Single pixel at origin: shift (15,15).
    img = '0;
    img[15 + W * 15] = 1'b1;
    canvas = '0;
    canvas[0] = 1'b1;
    do_start();
    run_stream("px00", img, 1, 1'b0, 1'b0, -1);
    chk_bbox("px00", 0, 0, 0, 0, 1'b0);

    // Single pixel at far corner: shift (-16,-16).
    canvas = '0;
    canvas[N - 1] = 1'b1;
    do_start();
    run_stream("px3131", img, 1, 1'b0, 1'b0, -1);
    chk_bbox("px3131", 31, 31, 31, 31, 1'b0);

    // 4x6 block: shift_x=12, shift_y=-7.
    canvas = rect(2, 5, 20, 25);
    do_start();
    run_stream("block", rect(14, 17, 13, 18), 24, 1'b0, 1'b0, -1);
    chk_bbox("block", 2, 5, 20, 25, 1'b0);

    // 3x3 at x=10..12, y=0..2: shift_x=4, shift_y=floor(29/2)=14; random stalls,
    // canvas overwritten and start pulsed mid-stream.
    canvas = rect(10, 12, 0, 2);
    do_start();
    run_stream("stall", rect(14, 16, 14, 16), 9, 1'b1, 1'b1, -1);
    chk_bbox("stall", 10, 12, 0, 2, 1'b0);

    // Reset at pixel 500, then a clean rerun.
    canvas = '0;
    canvas[0] = 1'b1;
    do_start();
    run_stream("abort", img, 1, 1'b0, 1'b0, 500);
    chk_bbox("abort", 0, 0, 0, 0, 1'b0);
    do_start();
    run_stream("rerun", img, 1, 1'b0, 1'b0, -1);
    chk_bbox("rerun", 0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
